// File: rtl/cf_apb_irq_regs.sv
// APB system-register front-end: IM/MIS/RIS/IC/GCLK window at 0xFF00-0xFF10, core pass-through elsewhere.
// Define CF_IRQ_SYNC_EN to put a 2-flop synchroniser in front of the flag sampling stage.
module cf_apb_irq_regs #(
  parameter int unsigned          NUM_IRQ   = 9,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK = '0
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [31:0]        PADDR,
  input  logic [31:0]        PWDATA,
  output logic               PREADY,
  output logic [31:0]        PRDATA,
  output logic               core_stb,
  input  logic               core_ack,
  input  logic [31:0]        core_rdata,
  input  logic [NUM_IRQ-1:0] flags,
  output logic               clk_en,
  output logic               irq
);

  localparam logic [7:0]  OFF_IM   = 8'h00;
  localparam logic [7:0]  OFF_MIS  = 8'h04;
  localparam logic [7:0]  OFF_RIS  = 8'h08;
  localparam logic [7:0]  OFF_IC   = 8'h0C;
  localparam logic [7:0]  OFF_GCLK = 8'h10;
  localparam logic [31:0] BAD_DATA = 32'hDEAD_BEEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  function automatic logic [31:0] zext(input logic [NUM_IRQ-1:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    r[NUM_IRQ-1:0] = v;
    return r;
  endfunction

  state_t               state_r, state_nxt;
  logic                 hit_s, ack_s, go_s;
  logic                 wr_im_s, wr_ic_s, wr_gclk_s;
  logic [NUM_IRQ-1:0]   flags_in_s;
  logic [NUM_IRQ-1:0]   flags_q_r, flags_d_r, edge_ris_r, im_r;
  logic [NUM_IRQ-1:0]   ris_s, mis_s, rise_s, ic_clr_s;
  logic                 gclk_r, irq_r;
  logic [31:0]          prdata_r, rdata_s;
  logic                 unused_bits;

  assign hit_s     = (PADDR[15:8] == 8'hFF);
  assign ack_s     = (state_r == ST_ACK);
  // ack_s gates a new decode so a held PSEL/PENABLE cannot re-trigger in the ACK cycle
  assign go_s      = PSEL & PENABLE & hit_s & ~ack_s;
  assign wr_im_s   = go_s & PWRITE & (PADDR[7:0] == OFF_IM);
  assign wr_ic_s   = go_s & PWRITE & (PADDR[7:0] == OFF_IC);
  assign wr_gclk_s = go_s & PWRITE & (PADDR[7:0] == OFF_GCLK);

  assign ris_s    = (edge_ris_r & EDGE_MASK) | (flags_q_r & ~EDGE_MASK);
  assign mis_s    = ris_s & im_r;
  assign rise_s   = flags_q_r & ~flags_d_r & EDGE_MASK;
  assign ic_clr_s = wr_ic_s ? PWDATA[NUM_IRQ-1:0] : {NUM_IRQ{1'b0}};

  assign unused_bits = ^{PADDR[31:16], PWDATA};

`ifdef CF_IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_r, sync2_r;

  // Two-flop synchroniser for asynchronous flag sources
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      sync1_r <= {NUM_IRQ{1'b0}};
      sync2_r <= {NUM_IRQ{1'b0}};
    end else begin
      sync1_r <= flags;
      sync2_r <= sync1_r;
    end
  end

  assign flags_in_s = sync2_r;
`else
  assign flags_in_s = flags;
`endif

  // Access FSM next state
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_s) begin
          state_nxt = ST_ACK;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read mux, sampled into PRDATA on the ACK edge
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (PADDR[7:0])
      OFF_IM:   rdata_s = zext(im_r);
      OFF_MIS:  rdata_s = zext(mis_s);
      OFF_RIS:  rdata_s = zext(ris_s);
      OFF_IC:   rdata_s = 32'h0000_0000;
      OFF_GCLK: rdata_s = {31'h0000_0000, gclk_r};
      default:  rdata_s = BAD_DATA;
    endcase
  end

  // FSM, registers and interrupt state
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_r    <= ST_IDLE;
      flags_q_r  <= {NUM_IRQ{1'b0}};
      flags_d_r  <= {NUM_IRQ{1'b0}};
      edge_ris_r <= {NUM_IRQ{1'b0}};
      im_r       <= {NUM_IRQ{1'b0}};
      gclk_r     <= 1'b0;
      irq_r      <= 1'b0;
      prdata_r   <= 32'h0000_0000;
    end else begin
      state_r    <= state_nxt;
      flags_q_r  <= flags_in_s;
      flags_d_r  <= flags_q_r;
      // set term applied last so a same-cycle rise beats the IC clear
      edge_ris_r <= ((edge_ris_r & ~ic_clr_s) | rise_s) & EDGE_MASK;
      irq_r      <= |mis_s;
      if (wr_im_s) begin
        im_r <= PWDATA[NUM_IRQ-1:0];
      end
      if (wr_gclk_s) begin
        gclk_r <= PWDATA[0];
      end
      if (go_s) begin
        prdata_r <= rdata_s;
      end
    end
  end

  assign PREADY   = hit_s ? ack_s : core_ack;
  assign PRDATA   = hit_s ? prdata_r : core_rdata;
  assign core_stb = PSEL & PENABLE & ~hit_s;
  assign clk_en   = gclk_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_cf_apb_irq_regs.sv
// Directed + randomized bench for cf_apb_irq_regs with a behavioural interrupt/register model.
module tb_cf_apb_irq_regs;

  localparam int          N    = 9;
  localparam logic [8:0]  EM   = 9'h0C1;
  localparam logic [31:0] EM32 = 32'h0000_00C1;
  localparam logic [31:0] MASK = 32'h0000_01FF;

  logic        PCLK = 1'b0;
  logic        PRESETn, PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA, core_rdata;
  logic        PREADY, core_stb, core_ack, clk_en, irq;
  logic [N-1:0] flags;

  int errors = 0;
  int checks = 0;

  // model state: what the block should hold after the most recent edge
  logic [31:0] m_im, m_sticky, m_seen1, m_seen2, m_gclk;
  logic        m_irq;
  bit          acc_edge = 1'b0;

  cf_apb_irq_regs #(.NUM_IRQ(N), .EDGE_MASK(EM)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA),
    .core_stb(core_stb), .core_ack(core_ack), .core_rdata(core_rdata),
    .flags(flags), .clk_en(clk_en), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // level sources show the last sampled flag, edge sources show the sticky latch
  function automatic logic [31:0] m_ris();
    return (m_sticky & EM32) | (m_seen1 & ~EM32);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[15:0])
      16'hFF00: return m_im;
      16'hFF04: return m_ris() & m_im;
      16'hFF08: return m_ris();
      16'hFF0C: return 32'h0;
      16'hFF10: return m_gclk;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic cycle();
    logic [31:0] rising, clr;
    logic        nirq;
    if (!PRESETn) begin
      m_im = 32'h0; m_sticky = 32'h0; m_seen1 = 32'h0; m_seen2 = 32'h0;
      m_gclk = 32'h0; m_irq = 1'b0;
    end else begin
      nirq   = |(m_ris() & m_im);
      rising = m_seen1 & ~m_seen2 & EM32;
      clr    = (acc_edge && PWRITE && PADDR[15:0] == 16'hFF0C) ? PWDATA : 32'h0;
      m_sticky = (m_sticky & ~clr) | rising;
      m_seen2  = m_seen1;
      m_seen1  = {23'h0, flags};
      if (acc_edge && PWRITE && PADDR[15:0] == 16'hFF00) m_im = PWDATA & MASK;
      if (acc_edge && PWRITE && PADDR[15:0] == 16'hFF10) m_gclk = PWDATA & 32'h1;
      m_irq = nirq;
    end
    @(posedge PCLK);
    #1;
    check("irq", {31'h0, irq}, {31'h0, m_irq});
    check("clk_en", {31'h0, clk_en}, m_gclk);
  endtask

  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
    logic [31:0] exp;
    PADDR = addr; PWRITE = wr; PWDATA = wdata; PSEL = 1'b1; PENABLE = 1'b0;
    cycle();
    PENABLE = 1'b1;
    #1;
    check("pready_wait", {31'h0, PREADY}, 32'h0);
    exp = m_read(addr);
    acc_edge = 1'b1;
    cycle();
    acc_edge = 1'b0;
    check("pready_ack", {31'h0, PREADY}, 32'h1);
    rdata = PRDATA;
    if (!wr) check("read_data", PRDATA, exp);
    cycle();
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
    check("pready_done", {31'h0, PREADY}, 32'h0);
  endtask

  logic [31:0] rd, cd;
  logic [31:0] raddr [6] = '{32'hFF00, 32'hFF04, 32'hFF08, 32'hFF0C, 32'hFF10, 32'hFF3C};
  int op;

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'hFF00; PWDATA = 32'h0; core_ack = 1'b0; core_rdata = 32'h0; flags = '0;
    cycle(); cycle();
    check("rst_pready", {31'h0, PREADY}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_clk_en", {31'h0, clk_en}, 32'h0);
    PRESETn = 1'b1;
    cycle();

    xfer(32'hFF08, 1'b0, 32'h0, rd); check("rst_ris", rd, 32'h0);
    xfer(32'hFF00, 1'b0, 32'h0, rd); check("rst_im", rd, 32'h0);
    xfer(32'hFF10, 1'b0, 32'h0, rd); check("rst_gclk", rd, 32'h0);

    // edge source 0: one-cycle pulse latches
    xfer(32'hFF00, 1'b1, 32'h1FF, rd);
    flags = 9'h001; cycle();
    flags = 9'h000; cycle(); cycle(); cycle();
    xfer(32'hFF08, 1'b0, 32'h0, rd); check("edge_sticky", rd, 32'h1);
    check("edge_irq", {31'h0, irq}, 32'h1);
    xfer(32'hFF0C, 1'b1, 32'h1, rd);
    check("ic_irq_low", {31'h0, irq}, 32'h0);
    xfer(32'hFF08, 1'b0, 32'h0, rd); check("ic_cleared", rd, 32'h0);

    // level source 3 ignores IC
    flags = 9'h008; cycle();
    xfer(32'hFF08, 1'b0, 32'h0, rd); check("level_set", rd, 32'h8);
    xfer(32'hFF0C, 1'b1, 32'h8, rd);
    xfer(32'hFF08, 1'b0, 32'h0, rd); check("level_ic", rd, 32'h8);
    flags = 9'h000; cycle();
    xfer(32'hFF08, 1'b0, 32'h0, rd); check("level_drop", rd, 32'h0);

    // rise of source 0 coincides with the IC ack edge
    cycle(); cycle();
    flags = 9'h001;
    xfer(32'hFF0C, 1'b1, 32'h1, rd);
    flags = 9'h000;
    xfer(32'hFF08, 1'b0, 32'h0, rd); check("set_wins", rd, 32'h1);

    xfer(32'hFF10, 1'b1, 32'h1, rd);
    check("gclk_clk_en", {31'h0, clk_en}, 32'h1);

    // core region pass-through
    cd = $urandom;
    PADDR = 32'h0000_0004; PWRITE = 1'b1; PWDATA = 32'h0; PSEL = 1'b1; PENABLE = 1'b0;
    #1; check("core_stb_setup", {31'h0, core_stb}, 32'h0);
    cycle();
    PENABLE = 1'b1; core_ack = 1'b0; core_rdata = cd;
    #1; check("core_stb", {31'h0, core_stb}, 32'h1);
    check("core_wait", {31'h0, PREADY}, 32'h0);
    core_ack = 1'b1;
    #1; check("core_ready", {31'h0, PREADY}, 32'h1);
    check("core_rdata", PRDATA, cd);
    cycle();
    PSEL = 1'b0; PENABLE = 1'b0; core_ack = 1'b0;
    xfer(32'hFF00, 1'b0, 32'h0, rd); check("im_kept", rd, 32'h1FF);
    xfer(32'hFF20, 1'b0, 32'h0, rd); check("bad_addr", rd, 32'hDEAD_BEEF);

    for (int i = 0; i < 200; i++) begin
      flags = 9'($urandom);
      op = int'($urandom_range(0, 4));
      case (op)
        0: cycle();
        1: xfer(32'hFF00, 1'b1, $urandom, rd);
        2: xfer(32'hFF0C, 1'b1, $urandom, rd);
        3: xfer(raddr[$urandom_range(0, 5)], 1'b0, $urandom, rd);
        default: xfer(32'hFF10, 1'b1, $urandom, rd);
      endcase
    end
    flags = '0;

    // reset during the access phase of an IM write
    PADDR = 32'hFF00; PWRITE = 1'b1; PWDATA = 32'h1FF; PSEL = 1'b1; PENABLE = 1'b0;
    cycle();
    PENABLE = 1'b1; PRESETn = 1'b0;
    cycle();
    check("midrst_pready", {31'h0, PREADY}, 32'h0);
    PRESETn = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    cycle();
    xfer(32'hFF00, 1'b0, 32'h0, rd); check("midrst_im", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
